// File: rtl/mp0_mem_responder_pkg.sv
// rtl/mp0_mem_responder_pkg.sv - shared types for the mp0 memory responder
// Purpose: rv32i_types holds the basic RV32I word type. mem_responder_types
//          holds the responder FSM state enum.
// Ports:   none (packages only).
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package mem_responder_types;
  import rv32i_types::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes per storage word; byte lanes are indexed 0..BYTES-1.
  localparam int BYTES = 4;
endpackage

// File: rtl/mp0_mem_responder_if.sv
// rtl/mp0_mem_responder_if.sv - initiator/responder memory bus
// Purpose: bundles the mp0 memory handshake. The initiator holds mem_read or
//          mem_write until mem_resp pulses for one cycle.
// Ports:   master: drives mem_read, mem_write, mem_byte_enable, mem_address,
//                  mem_wdata; receives mem_rdata, mem_resp (and mem_err).
//          slave:  the mirror image.
// Option:  MP0_MEM_RESPONDER_BOUNDS_CHECK_EN adds the mem_err signal.
interface mp0_mem_responder_if;
  import rv32i_types::*;

  logic      mem_read;
  logic      mem_write;
  logic [3:0] mem_byte_enable;
  rv32i_word mem_address;
  rv32i_word mem_wdata;
  rv32i_word mem_rdata;
  logic      mem_resp;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
  logic      mem_err;
`endif

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
    , input mem_err
`endif
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
    , output mem_err
`endif
  );
endinterface

// File: rtl/mp0_mem_responder_sram.sv
// rtl/mp0_mem_responder_sram.sv - byte-masked word storage with registered read
// Purpose: DEPTH_WORDS x 32-bit storage. Writes update only the lanes set in
//          wmask. Reads land in an output register that holds until the next
//          read. Storage itself is never reset; only the read register is.
// Ports:   clk, rst_n (async, active-low), idx (word index), wmask (byte
//          lanes), we (write enable), re (read enable), wdata, rdata.
module mem_responder_sram
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [3:0]                     wmask,
  input  logic                           we,
  input  logic                           re,
  input  rv32i_word                      wdata,
  output rv32i_word                      rdata
);
  rv32i_word mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && wmask[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/mp0_mem_responder.sv
// rtl/mp0_mem_responder.sv - fixed-latency memory responder for the mp0 bus
// Purpose: samples a read/write request in IDLE, waits LATENCY cycles, then
//          pulses mem_resp for one cycle. Reads update mem_rdata on the
//          response; writes leave it alone. Read+write together is a write.
// Ports:   clk, rst_n (async, active-low), bus (mp0_mem_responder_if.slave).
// Params:  DEPTH_WORDS (power of two, >= 4), LATENCY (>= 1).
// Option:  MP0_MEM_RESPONDER_BOUNDS_CHECK_EN flags out-of-range addresses on
//          mem_err, drops such writes and returns zero for such reads;
//          without it addresses wrap modulo DEPTH_WORDS.
module mp0_mem_responder
  import rv32i_types::*;
  import mem_responder_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  mp0_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   lat_idx;
  rv32i_word       lat_wdata;
  logic [3:0]      lat_be;
  logic            lat_write;
  logic            resp_q;

  logic            req;
  logic            from_idle;
  logic            go_resp;
  logic [AW-1:0]   acc_idx;
  rv32i_word       acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_write;
  logic            acc_err;
  logic            sram_we;
  logic            sram_re;
  rv32i_word       sram_rdata;
  logic            unused_addr;

  assign req       = bus.mem_read | bus.mem_write;
  assign from_idle = (state == IDLE);

  // The storage access happens on the edge that enters RESP so the read
  // register is already valid during the response cycle. With LATENCY=1
  // that edge is the sampling edge, so the live inputs feed the SRAM;
  // otherwise the latched copy does.
  assign go_resp = rst_n &&
                   ((from_idle && req && (LATENCY == 1)) ||
                    ((state == BUSY) && (cnt == CNT_ONE)));

  assign acc_idx   = from_idle ? bus.mem_address[2 +: AW] : lat_idx;
  assign acc_wdata = from_idle ? bus.mem_wdata           : lat_wdata;
  assign acc_be    = from_idle ? bus.mem_byte_enable     : lat_be;
  assign acc_write = from_idle ? bus.mem_write           : lat_write;

  // Bits [1:0] are ignored and upper bits only matter for the bounds check.
  assign unused_addr = ^bus.mem_address;

`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
  logic lat_err;
  logic err_q;
  logic rd_zero;
  logic live_err;

  assign live_err = ({2'b00, bus.mem_address[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_err  = from_idle ? live_err : lat_err;
`else
  assign acc_err  = 1'b0;
`endif

  assign sram_we = go_resp & acc_write & ~acc_err;
  assign sram_re = go_resp & ~acc_write;

  mem_responder_sram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (acc_idx),
    .wmask (acc_be),
    .we    (sram_we),
    .re    (sram_re),
    .wdata (acc_wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_q    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_write <= 1'b0;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
      lat_err   <= 1'b0;
      err_q     <= 1'b0;
      rd_zero   <= 1'b0;
`endif
    end else begin
      resp_q <= 1'b0;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
      err_q  <= 1'b0;
      // An out-of-range read masks the SRAM word until the next read.
      if (sram_re) begin
        rd_zero <= acc_err;
      end
`endif
      case (state)
        IDLE: begin
          if (req) begin
            lat_idx   <= bus.mem_address[2 +: AW];
            lat_wdata <= bus.mem_wdata;
            lat_be    <= bus.mem_byte_enable;
            lat_write <= bus.mem_write;
            cnt       <= CNT_LOAD;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
            lat_err   <= acc_err;
`endif
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_q <= 1'b1;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
              err_q  <= acc_err;
`endif
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= RESP;
            resp_q <= 1'b1;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
            err_q  <= acc_err;
`endif
          end
        end
        RESP: begin
          // Always one IDLE cycle before the next request is sampled.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_resp = resp_q;
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
  assign bus.mem_rdata = rd_zero ? '0 : sram_rdata;
  assign bus.mem_err   = err_q;
`else
  assign bus.mem_rdata = sram_rdata;
`endif
endmodule

// File: tb/tb_mp0_mem_responder.sv
// tb/tb_mp0_mem_responder.sv - self-checking bench for mp0_mem_responder
module tb_mp0_mem_responder;
  localparam int L0    = 3;
  localparam int L1    = 1;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_cnt = 0;

  mp0_mem_responder_if bus0 ();
  mp0_mem_responder_if bus1 ();

  mp0_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mp0_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model of dut0: a request seen while idle completes on the L0-th edge
  // counting the sampling edge; the edge after a completion never samples.
  logic [31:0] mm [int];
  logic        exp_resp  = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          rd_known  = 1'b1;
  bit          pend      = 1'b0;
  int          ecount    = 0;
  int          due       = 0;
  int          blk       = -1;
  logic        m_wr;
  logic [31:0] m_a;
  logic [31:0] m_d;
  logic [3:0]  m_be;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 1'b0;
      exp_resp = 1'b0;
      exp_err = 1'b0;
      exp_rdata = 32'h0;
      rd_known = 1'b1;
      blk = -1;
    end else begin
      bit oob;
      int wi;
      logic [31:0] t;
      ecount++;
      exp_resp = 1'b0;
      exp_err = 1'b0;
      if (!pend && ecount != blk && (bus0.mem_read || bus0.mem_write)) begin
        pend = 1'b1;
        due  = ecount + L0 - 1;
        m_wr = bus0.mem_write;
        m_a  = bus0.mem_address;
        m_d  = bus0.mem_wdata;
        m_be = bus0.mem_byte_enable;
      end
      if (pend && ecount == due) begin
        pend = 1'b0;
        blk = ecount + 1;
        exp_resp = 1'b1;
        wi = int'((m_a >> 2) % DEPTH);
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
        oob = ((m_a >> 2) >= DEPTH);
        exp_err = oob;
`else
        oob = 1'b0;
`endif
        if (m_wr) begin
          if (!oob) begin
            if (mm.exists(wi)) begin
              t = mm[wi];
              for (int i = 0; i < 4; i++) if (m_be[i]) t[8*i +: 8] = m_d[8*i +: 8];
              mm[wi] = t;
            end else if (m_be == 4'hF) begin
              mm[wi] = m_d;
            end
          end
        end else if (oob) begin
          exp_rdata = 32'h0;
          rd_known = 1'b1;
        end else if (mm.exists(wi)) begin
          exp_rdata = mm[wi];
          rd_known = 1'b1;
        end else begin
          rd_known = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.mem_resp) resp_cnt++;
    chk("resp", 32'(bus0.mem_resp), 32'(exp_resp));
    if (rd_known) chk("rdata", bus0.mem_rdata, exp_rdata);
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
    chk("err", 32'(bus0.mem_err), 32'(exp_err));
`endif
  end

  task automatic drive(input int which, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (which == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_address = a;
      bus0.mem_wdata = d; bus0.mem_byte_enable = be;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_address = a;
      bus1.mem_wdata = d; bus1.mem_byte_enable = be;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic op(input int which, input logic rd, input logic wr,
                    input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                    input bit hold, input bit scramble, output logic [31:0] rdata);
    int n;
    bit seen;
    logic r;
    drive(which, rd, wr, a, d, be);
    n = 0;
    seen = 1'b0;
    rdata = 32'h0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      r = (which == 0) ? bus0.mem_resp : bus1.mem_resp;
      if (r) begin
        seen = 1'b1;
        rdata = (which == 0) ? bus0.mem_rdata : bus1.mem_rdata;
      end else if (scramble && n == 2) begin
        drive(which, rd, wr, a ^ 32'h40, ~d, ~be);
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no mem_resp within %0d cycles for addr %h", n, a);
    end else begin
      chk("latency", 32'(n - 1), 32'((which == 0) ? L0 : L1));
    end
    @(posedge clk);
    #1;
    if (!hold) drive(which, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] r;
    int rc;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp0", 32'(bus0.mem_resp), 32'h0);
    chk("reset_rdata0", bus0.mem_rdata, 32'h0);
    chk("reset_resp1", 32'(bus1.mem_resp), 32'h0);
    chk("reset_rdata1", bus1.mem_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full write, read back, partial write, zero-mask write.
    op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, r);
    op(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("full_write_read", r, 32'hDEADBEEF);
    op(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b0, r);
    chk("write_keeps_rdata", r, 32'hDEADBEEF);
    op(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("partial_write_read", r, 32'hDE22BE44);
    op(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, r);
    op(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("zero_mask_write", r, 32'hDE22BE44);

    // Back-to-back reads with the first held through its response.
    op(0, 1'b0, 1'b1, 32'h14, 32'h13579BDF, 4'hF, 1'b0, 1'b0, r);
    rc = resp_cnt;
    op(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, r);
    chk("b2b_first", r, 32'hDE22BE44);
    op(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("b2b_second", r, 32'h13579BDF);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_resp_count", 32'(resp_cnt - rc), 32'd2);

    // Inputs changed while busy are ignored.
    op(0, 1'b0, 1'b1, 32'h18, 32'h24681357, 4'hF, 1'b0, 1'b1, r);
    op(0, 1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("busy_inputs_ignored", r, 32'h24681357);

    // Reset while busy discards the pending write.
    op(0, 1'b0, 1'b1, 32'h20, 32'h55555555, 4'hF, 1'b0, 1'b0, r);
    drive(0, 1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rc = resp_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_resp", 32'(resp_cnt - rc), 32'd0);
    op(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("abort_no_write", r, 32'h55555555);

    // Address beyond the array.
    op(0, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, r);
    op(0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 1'b0, 1'b0, r);
`ifdef MP0_MEM_RESPONDER_BOUNDS_CHECK_EN
    chk("oob_read_zero", r, 32'h0);
`else
    chk("wrap_read", r, 32'h0BADF00D);
`endif

    // LATENCY=1 instance: read+write together acts as a write.
    op(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, r);
    op(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("l1_read", r, 32'hCAFEF00D);
    op(1, 1'b1, 1'b1, 32'h8, 32'h11112222, 4'hF, 1'b0, 1'b0, r);
    chk("l1_both_keeps_rdata", r, 32'hCAFEF00D);
    op(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, r);
    chk("l1_both_wrote", r, 32'h11112222);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
